// File: rtl/vsync_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : vsync_mode_sequencer
// Description : Wishbone master that reprograms a vsync_generator for a new
//               video mode: disable, poll until idle, load 12 timing
//               registers from a built-in table, then re-enable.
// Revision    : 1.0 - initial release
// ============================================================================
module vsync_mode_sequencer #(
  parameter int WB_ADR_WIDTH = 8,
  parameter int WB_DAT_WIDTH = 32,
  parameter int WB_SEL_WIDTH = WB_DAT_WIDTH / 8,
  parameter int POLL_TIMEOUT = 65535
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ctl_start,
  input  logic [1:0]              ctl_mode,
  output logic                    stat_busy,
  output logic                    stat_done,
  output logic                    stat_error,
  output logic [WB_ADR_WIDTH-1:0] m_wb_adr_o,
  output logic [WB_DAT_WIDTH-1:0] m_wb_dat_o,
  input  logic [WB_DAT_WIDTH-1:0] m_wb_dat_i,
  output logic                    m_wb_we_o,
  output logic [WB_SEL_WIDTH-1:0] m_wb_sel_o,
  output logic                    m_wb_stb_o,
  input  logic                    m_wb_ack_i
);

  localparam int c_cnt_w       = $clog2(POLL_TIMEOUT + 1);
  localparam int c_adr_control = 4;
  localparam int c_adr_status  = 5;

  // Register order: HTOTAL, HDISP_START, HDISP_END, HSYNC_START, HSYNC_END,
  // HSYNC_POL, VTOTAL, VDISP_START, VDISP_END, VSYNC_START, VSYNC_END, VSYNC_POL
  localparam logic [0:11][4:0] c_load_adr = '{
    5'd8, 5'd12, 5'd13, 5'd14, 5'd15, 5'd11, 5'd16, 5'd20, 5'd21, 5'd22, 5'd23, 5'd19};
  localparam logic [0:11][10:0] c_tab0 = '{
    11'd800, 11'd112, 11'd752, 11'd0, 11'd96, 11'd0,
    11'd525, 11'd12, 11'd492, 11'd0, 11'd2, 11'd0};
  localparam logic [0:11][10:0] c_tab1 = '{
    11'd1056, 11'd168, 11'd968, 11'd0, 11'd128, 11'd1,
    11'd628, 11'd5, 11'd605, 11'd0, 11'd4, 11'd1};
  localparam logic [0:11][10:0] c_tab2 = '{
    11'd1650, 11'd150, 11'd1430, 11'd0, 11'd40, 11'd1,
    11'd750, 11'd10, 11'd730, 11'd0, 11'd5, 11'd1};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DIS  = 3'd1,
    S_POLL = 3'd2,
    S_LOAD = 3'd3,
    S_EN   = 3'd4
  } state_t;

  state_t                  r_state;
  logic [1:0]              r_mode;
  logic [3:0]              r_idx;
  logic [c_cnt_w-1:0]      r_cnt;
  logic                    r_stb;
  logic                    r_we;
  logic [WB_ADR_WIDTH-1:0] r_adr;
  logic [WB_DAT_WIDTH-1:0] r_dat;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_error;
  // High for the single cycle after a sequence ends, so a start coincident
  // with done/error is not accepted.
  logic                    r_fin;

  logic [10:0]             w_param;
  logic                    w_timeout;
  logic                    w_ack;
  logic                    w_unused;

  assign w_timeout = (r_cnt >= POLL_TIMEOUT[c_cnt_w-1:0]);
  assign w_ack     = r_stb & m_wb_ack_i;
  assign w_unused  = &{1'b0, m_wb_dat_i[WB_DAT_WIDTH-1:1]};

  // Timing value for the current LOAD slot of the latched mode
  always_comb begin
    w_param = c_tab0[r_idx];
    case (r_mode)
      2'd1:    w_param = c_tab1[r_idx];
      2'd2:    w_param = c_tab2[r_idx];
      default: w_param = c_tab0[r_idx];
    endcase
  end

  // Sequencer FSM: each access raises stb from a low cycle and drops it on ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_mode  <= 2'd0;
      r_idx   <= 4'd0;
      r_cnt   <= '0;
      r_stb   <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_fin   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_fin  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ctl_start && !r_fin) begin
            r_mode  <= ctl_mode;
            r_busy  <= 1'b1;
            r_error <= 1'b0;
            r_state <= S_DIS;
          end
        end
        S_DIS: begin
          if (!r_stb) begin
            r_stb <= 1'b1;
            r_we  <= 1'b1;
            r_adr <= WB_ADR_WIDTH'(c_adr_control);
            r_dat <= '0;
          end else if (w_ack) begin
            r_stb   <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_POLL;
          end
        end
        S_POLL: begin
          if (!w_timeout) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
          if (!r_stb) begin
            if (w_timeout) begin
              r_error <= 1'b1;
              r_busy  <= 1'b0;
              r_fin   <= 1'b1;
              r_we    <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_stb <= 1'b1;
              r_we  <= 1'b0;
              r_adr <= WB_ADR_WIDTH'(c_adr_status);
              r_dat <= '0;
            end
          end else if (w_ack) begin
            r_stb <= 1'b0;
            if (w_timeout) begin
              r_error <= 1'b1;
              r_busy  <= 1'b0;
              r_fin   <= 1'b1;
              r_state <= S_IDLE;
            end else if (!m_wb_dat_i[0]) begin
              if (r_mode == 2'd3) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_fin   <= 1'b1;
                r_state <= S_IDLE;
              end else begin
                r_idx   <= 4'd0;
                r_state <= S_LOAD;
              end
            end
          end
        end
        S_LOAD: begin
          if (!r_stb) begin
            r_stb <= 1'b1;
            r_we  <= 1'b1;
            r_adr <= WB_ADR_WIDTH'(c_load_adr[r_idx]);
            r_dat <= WB_DAT_WIDTH'(w_param);
          end else if (w_ack) begin
            r_stb <= 1'b0;
            if (r_idx == 4'd11) begin
              r_state <= S_EN;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        S_EN: begin
          if (!r_stb) begin
            r_stb <= 1'b1;
            r_we  <= 1'b1;
            r_adr <= WB_ADR_WIDTH'(c_adr_control);
            r_dat <= WB_DAT_WIDTH'(1);
          end else if (w_ack) begin
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_fin   <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_stb   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign m_wb_stb_o = r_stb;
  assign m_wb_we_o  = r_we;
  assign m_wb_adr_o = r_adr;
  assign m_wb_dat_o = r_dat;
  assign m_wb_sel_o = {WB_SEL_WIDTH{r_stb}};
  assign stat_busy  = r_busy;
  assign stat_done  = r_done;
  assign stat_error = r_error;

endmodule
`default_nettype wire
